// File: rtl/delay_udl_counter.sv
// Enabled 1-bit shift-register delay line plus a loadable modulo up/down counter.
// The counter can keep three voted copies of its state; RST clears only the counter.
module delay_udl_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned TMR   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SRL_CE,
  input  logic             SRL_I,
  output logic             SRL_O,
  input  logic             CE,
  input  logic             L,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  // Stages carry no reset so they can pack into LUT shift registers.
  logic [DEPTH-1:0] srl_q = '0;
  logic [DEPTH-1:0] srl_d;
  logic [DEPTH:0]   srl_shift;

  always_comb begin
    srl_shift = {srl_q, SRL_I};
    srl_d     = srl_shift[DEPTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (SRL_CE) begin
      srl_q <= srl_d;
    end
  end

  assign SRL_O = srl_q[DEPTH-1];

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_vote;

  // Next state always derives from the voted value, which scrubs an upset copy.
  always_comb begin
    cnt_d = cnt_vote;
    if (L) begin
      cnt_d = D;
    end else if (CE) begin
      cnt_d = UP ? cnt_vote + One : cnt_vote - One;
    end
  end

  if (TMR != 0) begin : g_tmr
    (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] cnt0_q;
    (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] cnt1_q;
    (* dont_touch = "true", keep = "true" *) logic [WIDTH-1:0] cnt2_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
        cnt2_q <= '0;
      end else begin
        cnt0_q <= cnt_d;
        cnt1_q <= cnt_d;
        cnt2_q <= cnt_d;
      end
    end

    assign cnt_vote = (cnt0_q & cnt1_q) | (cnt0_q & cnt2_q) | (cnt1_q & cnt2_q);
  end else begin : g_plain
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_vote = cnt_q;
  end

  assign Q = cnt_vote;

endmodule

// File: tb/tb_delay_udl_counter.sv
// Scoreboard bench for delay_udl_counter: a driver pushes model predictions per cycle,
// a negedge monitor pops them and compares three instances (DEPTH 16/64, TMR on/off).
module tb_delay_udl_counter;

  logic       CLK    = 1'b0;
  logic       RST    = 1'b1;
  logic       SRL_CE = 1'b0;
  logic       SRL_I  = 1'b0;
  logic       CE     = 1'b0;
  logic       L      = 1'b0;
  logic       UP     = 1'b0;
  logic [1:0] D      = 2'd0;

  logic       o16, o64, otmr;
  logic [1:0] q16, q64, qtmr;
  logic [1:0] bad;

  always #5 CLK = ~CLK;

  delay_udl_counter #(.DEPTH(16), .WIDTH(2), .TMR(0)) dut (
    .CLK(CLK), .RST(RST), .SRL_CE(SRL_CE), .SRL_I(SRL_I), .SRL_O(o16),
    .CE(CE), .L(L), .UP(UP), .D(D), .Q(q16)
  );

  delay_udl_counter #(.DEPTH(64), .WIDTH(2), .TMR(0)) dut64 (
    .CLK(CLK), .RST(RST), .SRL_CE(SRL_CE), .SRL_I(SRL_I), .SRL_O(o64),
    .CE(CE), .L(L), .UP(UP), .D(D), .Q(q64)
  );

  delay_udl_counter #(.DEPTH(16), .WIDTH(2), .TMR(1)) dut_tmr (
    .CLK(CLK), .RST(RST), .SRL_CE(SRL_CE), .SRL_I(SRL_I), .SRL_O(otmr),
    .CE(CE), .L(L), .UP(UP), .D(D), .Q(qtmr)
  );

  typedef struct packed {
    logic       o16;
    logic       o64;
    logic [1:0] q;
  } exp_t;

  exp_t exp_q[$];
  bit   h16[$];
  bit   h64[$];
  int   m;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: each delay line is a FIFO of the last DEPTH enabled samples (front = output);
  // the counter is an integer taken modulo 4.
  task automatic step(input logic rst, input logic sce, input logic si, input logic ce,
                      input logic ld, input logic up, input logic [1:0] d, input bit ovl);
    exp_t e;
    @(posedge CLK);
    if (SRL_CE) begin
      h16.push_back(SRL_I);
      void'(h16.pop_front());
      h64.push_back(SRL_I);
      void'(h64.pop_front());
    end
    if (RST) m = 0;
    else if (L) m = int'(D);
    else if (CE) m = UP ? (m + 1) % 4 : (m + 3) % 4;
    #2;
    RST    = rst;
    SRL_CE = sce;
    SRL_I  = si;
    L      = ld;
    D      = d;
    if (ovl) begin
      CE = si ^ h16[0];
      UP = si;
    end else begin
      CE = ce;
      UP = up;
    end
    if (rst) m = 0;
    e.o16 = h16[0];
    e.o64 = h64[0];
    e.q   = 2'(m);
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("srl_o16", 32'(o16), 32'(e.o16));
        check("srl_o64", 32'(o64), 32'(e.o64));
        check("srl_otmr", 32'(otmr), 32'(e.o16));
        check("q16", 32'(q16), 32'(e.q));
        check("q64", 32'(q64), 32'(e.q));
        check("qtmr", 32'(qtmr), 32'(e.q));
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) h16.push_back(1'b0);
    for (int i = 0; i < 64; i++) h64.push_back(1'b0);
    m = 0;

    // Reset held; delay lines must read 0 from power-up.
    repeat (3) step(1, 1, 0, 0, 0, 0, 2'd0, 0);

    // Single pulse through the 16-deep line.
    step(0, 1, 1, 0, 0, 0, 2'd0, 0);
    repeat (20) step(0, 1, 0, 0, 0, 0, 2'd0, 0);

    // Pulse with a 10-cycle shift stall mid-flight.
    step(0, 1, 1, 0, 0, 0, 2'd0, 0);
    repeat (20) step(0, 1, 0, 0, 0, 0, 2'd0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 2'd0, 0);
    repeat (60) step(0, 1, 0, 0, 0, 0, 2'd0, 0);

    // Counter wrap up, then down through zero.
    step(1, 1, 0, 0, 0, 0, 2'd0, 0);
    repeat (5) step(0, 1, 0, 1, 0, 1, 2'd0, 0);
    repeat (3) step(0, 1, 0, 1, 0, 0, 2'd0, 0);

    // Load priority over count enable.
    step(0, 1, 0, 0, 1, 0, 2'd2, 0);
    step(0, 1, 0, 1, 1, 1, 2'd1, 0);
    step(0, 1, 0, 0, 0, 0, 2'd0, 0);

    // Asynchronous reset between edges.
    @(negedge CLK);
    #1 RST = 1'b1;
    m = 0;
    #1;
    check("async_rst_q16", 32'(q16), 32'd0);
    check("async_rst_q64", 32'(q64), 32'd0);
    check("async_rst_qtmr", 32'(qtmr), 32'd0);
    repeat (4) step(0, 1, 0, 1, 0, 1, 2'd0, 0);

    // Upset one TMR copy; vote hides it and the next update scrubs it.
    step(0, 1, 0, 0, 1, 0, 2'd1, 0);
    step(0, 1, 0, 0, 0, 0, 2'd0, 0);
    @(negedge CLK);
    #1 bad = ~2'(m);
    force dut_tmr.g_tmr.cnt1_q = bad;
    #1;
    check("tmr_vote", 32'(qtmr), 32'(m));
    release dut_tmr.g_tmr.cnt1_q;
    step(0, 1, 0, 1, 0, 1, 2'd0, 0);
    step(0, 1, 0, 0, 0, 0, 2'd0, 0);
    check("tmr_copy1", 32'(dut_tmr.g_tmr.cnt1_q), 32'(m));

    // Overlap counting: pulses at t=0 and t=5 through the 16-deep window.
    step(1, 1, 0, 0, 0, 0, 2'd0, 0);
    repeat (17) step(0, 1, 0, 0, 0, 0, 2'd0, 0);
    step(0, 1, 1, 0, 0, 0, 2'd0, 1);
    repeat (4) step(0, 1, 0, 0, 0, 0, 2'd0, 1);
    step(0, 1, 1, 0, 0, 0, 2'd0, 1);
    repeat (25) step(0, 1, 0, 0, 0, 0, 2'd0, 1);

    // Randomized traffic.
    repeat (400) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom), 2'($urandom), 0);
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
